// File: rtl/llsc_reservation_monitor.sv
// Two-core load-linked / store-conditional reservation monitor with cross-core store snooping.
// Defining LLSC_TIMEOUT_EN adds a per-core reservation lifetime of TIMEOUT_CYCLES cycles.
module llsc_reservation_monitor #(
   parameter int ADDR_W         = 32,
   parameter int GRAN_LSB       = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_ll,
   input  logic              p0_sc,
   input  logic              p0_st,
   input  logic [ADDR_W-1:0] p0_adr,
   input  logic              p1_ll,
   input  logic              p1_sc,
   input  logic              p1_st,
   input  logic [ADDR_W-1:0] p1_adr,
   output logic              p0_sc_grant,
   output logic              p1_sc_grant,
   output logic              p0_success,
   output logic              p1_success,
   output logic              p0_sc_done,
   output logic              p1_sc_done,
   output logic              p0_linked,
   output logic              p1_linked
);

   localparam int TAG_W = ADDR_W - GRAN_LSB;

   typedef enum logic {
      IDLE   = 1'b0,
      LINKED = 1'b1
   } state_t;

   state_t           state_q    [2];
   state_t           state_d    [2];
   logic [TAG_W-1:0] link_adr_q [2];
   logic [TAG_W-1:0] link_adr_d [2];
   logic [TAG_W-1:0] tag        [2];

   logic [1:0] sc;
   logic [1:0] ll;
   logic [1:0] st;
   logic [1:0] st_eff;
   logic [1:0] raw_grant;
   logic [1:0] grant;
   logic [1:0] kill;
   logic [1:0] expire;
   logic [1:0] success_q;
   logic [1:0] done_q;

   function automatic logic [TAG_W-1:0] granule(input logic [ADDR_W-1:0] adr);
      return adr[ADDR_W-1:GRAN_LSB];
   endfunction

   assign sc     = {p1_sc, p0_sc};
   assign ll     = {p1_ll, p0_ll};
   assign st     = {p1_st, p0_st};
   assign tag[0] = granule(p0_adr);
   assign tag[1] = granule(p1_adr);

   // Sub-granule address bits never take part in a reservation compare.
   logic unused_low_bits;
   assign unused_low_bits = ^{p0_adr[GRAN_LSB-1:0], p1_adr[GRAN_LSB-1:0]};

   // Request decode, SC arbitration and cross-core kill detection.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         st_eff[i]    = st[i] && !sc[i] && !ll[i];
         raw_grant[i] = sc[i] && (state_q[i] == LINKED) && (tag[i] == link_adr_q[i]);
      end
      grant[0] = raw_grant[0];
      grant[1] = raw_grant[1] && !(raw_grant[0] && (tag[0] == tag[1]));
      kill[0]  = (state_q[0] == LINKED) && (grant[1] || st_eff[1]) && (tag[1] == link_adr_q[0]);
      kill[1]  = (state_q[1] == LINKED) && (grant[0] || st_eff[0]) && (tag[0] == link_adr_q[1]);
   end

`ifdef LLSC_TIMEOUT_EN
   localparam int               AGE_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(TIMEOUT_CYCLES - 1);

   logic [AGE_W-1:0] age_q [2];

   // Age restarts on an accepted LL; an LL in the expiry cycle therefore renews the reservation.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            age_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (ll[i] && !sc[i]) begin
               age_q[i] <= '0;
            end else if (state_q[i] == LINKED) begin
               age_q[i] <= age_q[i] + AGE_W'(1);
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         expire[i] = (state_q[i] == LINKED) && (age_q[i] == AGE_LAST);
      end
   end
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
   assign expire = '0;
`endif

   // Next state: SC always drops the reservation, LL beats a same-cycle kill or expiry.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         state_d[i]    = state_q[i];
         link_adr_d[i] = link_adr_q[i];
         if (sc[i]) begin
            state_d[i] = IDLE;
         end else if (ll[i]) begin
            state_d[i]    = LINKED;
            link_adr_d[i] = tag[i];
         end else if (kill[i] || expire[i]) begin
            state_d[i] = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            state_q[i]    <= IDLE;
            link_adr_q[i] <= '0;
         end
         success_q <= '0;
         done_q    <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            state_q[i]    <= state_d[i];
            link_adr_q[i] <= link_adr_d[i];
            if (sc[i]) begin
               success_q[i] <= grant[i];
            end
         end
         done_q <= sc;
      end
   end

   // Outputs are forced low while reset is high, including a pending SC completion.
   always_comb begin
      p0_sc_grant = !reset && grant[0];
      p1_sc_grant = !reset && grant[1];
      p0_success  = !reset && success_q[0];
      p1_success  = !reset && success_q[1];
      p0_sc_done  = !reset && done_q[0];
      p1_sc_done  = !reset && done_q[1];
      p0_linked   = !reset && (state_q[0] == LINKED);
      p1_linked   = !reset && (state_q[1] == LINKED);
   end

endmodule

// File: tb/tb_llsc_reservation_monitor.sv
// Directed bench for llsc_reservation_monitor; timeout scenarios run when LLSC_TIMEOUT_EN is defined.
module tb_llsc_reservation_monitor;

   logic        clk = 1'b0;
   logic        reset;
   logic        p0_ll, p0_sc, p0_st;
   logic [31:0] p0_adr;
   logic        p1_ll, p1_sc, p1_st;
   logic [31:0] p1_adr;
   logic        p0_sc_grant, p1_sc_grant;
   logic        p0_success, p1_success;
   logic        p0_sc_done, p1_sc_done;
   logic        p0_linked, p1_linked;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   llsc_reservation_monitor #(
      .ADDR_W(32),
      .GRAN_LSB(2),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .p0_ll(p0_ll),
      .p0_sc(p0_sc),
      .p0_st(p0_st),
      .p0_adr(p0_adr),
      .p1_ll(p1_ll),
      .p1_sc(p1_sc),
      .p1_st(p1_st),
      .p1_adr(p1_adr),
      .p0_sc_grant(p0_sc_grant),
      .p1_sc_grant(p1_sc_grant),
      .p0_success(p0_success),
      .p1_success(p1_success),
      .p0_sc_done(p0_sc_done),
      .p1_sc_done(p1_sc_done),
      .p0_linked(p0_linked),
      .p1_linked(p1_linked)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_in();
      p0_ll = 1'b0; p0_sc = 1'b0; p0_st = 1'b0; p0_adr = '0;
      p1_ll = 1'b0; p1_sc = 1'b0; p1_st = 1'b0; p1_adr = '0;
   endtask

   // Inputs change 1 time unit after the rising edge and are cleared after the next one.
   task automatic tick();
      @(posedge clk);
      #1;
      clear_in();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic drive0(input logic ll, input logic sc, input logic st, input logic [31:0] a);
      p0_ll = ll; p0_sc = sc; p0_st = st; p0_adr = a;
      #1;
   endtask

   task automatic drive1(input logic ll, input logic sc, input logic st, input logic [31:0] a);
      p1_ll = ll; p1_sc = sc; p1_st = st; p1_adr = a;
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_outs"},
            {24'd0, p0_sc_grant, p1_sc_grant, p0_success, p1_success,
             p0_sc_done, p1_sc_done, p0_linked, p1_linked}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      clear_in();
      reset = 1'b1;
      tick();
      tick();
      check_all_zero("reset");
      drive0(1'b0, 1'b1, 1'b0, 32'h0);
      check("reset_grant", p0_sc_grant, 1'b0);
      tick();
      reset = 1'b0;
      tick();
      check_all_zero("post_reset");

      // Basic LL / SC success
      drive0(1'b1, 1'b0, 1'b0, 32'h100);
      tick();
      check("t1_linked", p0_linked, 1'b1);
      idle(3);
      drive0(1'b0, 1'b1, 1'b0, 32'h100);
      check("t1_grant", p0_sc_grant, 1'b1);
      tick();
      check("t1_done", p0_sc_done, 1'b1);
      check("t1_success", p0_success, 1'b1);
      check("t1_unlinked", p0_linked, 1'b0);
      tick();
      check("t1_done_pulse", p0_sc_done, 1'b0);
      check("t1_success_held", p0_success, 1'b1);

      // Other core's store to the same word kills the reservation
      drive0(1'b1, 1'b0, 1'b0, 32'h100);
      tick();
      drive1(1'b0, 1'b0, 1'b1, 32'h102);
      tick();
      check("t2_killed", p0_linked, 1'b0);
      drive0(1'b0, 1'b1, 1'b0, 32'h100);
      check("t2_grant", p0_sc_grant, 1'b0);
      tick();
      check("t2_done", p0_sc_done, 1'b1);
      check("t2_success", p0_success, 1'b0);

      // Simultaneous SCs to the same word: core 0 wins
      drive0(1'b1, 1'b0, 1'b0, 32'h200);
      drive1(1'b1, 1'b0, 1'b0, 32'h200);
      tick();
      check("t3_links", {p0_linked, p1_linked}, 2'b11);
      drive0(1'b0, 1'b1, 1'b0, 32'h200);
      drive1(1'b0, 1'b1, 1'b0, 32'h200);
      check("t3_grants", {p0_sc_grant, p1_sc_grant}, 2'b10);
      tick();
      check("t3_success", {p0_success, p1_success}, 2'b10);
      check("t3_done", {p0_sc_done, p1_sc_done}, 2'b11);
      check("t3_links_after", {p0_linked, p1_linked}, 2'b00);

      // LL beats a same-cycle kill
      drive1(1'b1, 1'b0, 1'b0, 32'h300);
      drive0(1'b0, 1'b0, 1'b1, 32'h300);
      tick();
      check("t4_linked", p1_linked, 1'b1);
      drive1(1'b0, 1'b1, 1'b0, 32'h300);
      check("t4_grant", p1_sc_grant, 1'b1);
      tick();
      check("t4_success", p1_success, 1'b1);

      // SC with no reservation, then SC to a mismatching word
      drive0(1'b0, 1'b1, 1'b0, 32'h400);
      check("t5_nolink_grant", p0_sc_grant, 1'b0);
      tick();
      check("t5_nolink_success", p0_success, 1'b0);
      check("t5_nolink_done", p0_sc_done, 1'b1);
      drive0(1'b1, 1'b0, 1'b0, 32'h500);
      tick();
      drive0(1'b0, 1'b1, 1'b0, 32'h504);
      check("t5_mismatch_grant", p0_sc_grant, 1'b0);
      tick();
      check("t5_mismatch_success", p0_success, 1'b0);
      check("t5_mismatch_linked", p0_linked, 1'b0);

      // Own store keeps the reservation; SC beats a same-cycle LL
      drive0(1'b1, 1'b0, 1'b0, 32'h600);
      tick();
      drive0(1'b0, 1'b0, 1'b1, 32'h600);
      tick();
      check("t6_own_store", p0_linked, 1'b1);
      drive0(1'b1, 1'b1, 1'b0, 32'h600);
      check("t6_prio_grant", p0_sc_grant, 1'b1);
      tick();
      check("t6_prio_linked", p0_linked, 1'b0);
      check("t6_prio_success", p0_success, 1'b1);

      // Back-to-back SCs: the second one fails
      drive1(1'b1, 1'b0, 1'b0, 32'h700);
      tick();
      drive1(1'b0, 1'b1, 1'b0, 32'h700);
      check("t7_first_grant", p1_sc_grant, 1'b1);
      tick();
      drive1(1'b0, 1'b1, 1'b0, 32'h700);
      check("t7_second_grant", p1_sc_grant, 1'b0);
      tick();
      check("t7_second_success", p1_success, 1'b0);

      // Granted SC kills the other core; a denied SC does not
      drive0(1'b1, 1'b0, 1'b0, 32'h900);
      drive1(1'b1, 1'b0, 1'b0, 32'h900);
      tick();
      drive1(1'b0, 1'b1, 1'b0, 32'h900);
      check("t8_grant1", p1_sc_grant, 1'b1);
      tick();
      check("t8_p0_killed", p0_linked, 1'b0);
      drive0(1'b1, 1'b0, 1'b0, 32'hA00);
      tick();
      drive1(1'b0, 1'b1, 1'b0, 32'hA00);
      check("t8_denied_grant", p1_sc_grant, 1'b0);
      tick();
      check("t8_no_kill", p0_linked, 1'b1);

      // Reset in the completion cycle of an SC
      drive0(1'b1, 1'b0, 1'b0, 32'h800);
      tick();
      drive0(1'b0, 1'b1, 1'b0, 32'h800);
      check("t9_grant", p0_sc_grant, 1'b1);
      tick();
      reset = 1'b1;
      #1;
      check("t9_done_suppressed", p0_sc_done, 1'b0);
      check("t9_success_forced", p0_success, 1'b0);
      tick();
      reset = 1'b0;
      tick();
      check_all_zero("t9_after_reset");

`ifdef LLSC_TIMEOUT_EN
      // LL in cycle T; SC in T+7 is still inside the lifetime
      drive0(1'b1, 1'b0, 1'b0, 32'hB00);
      tick();
      idle(6);
      drive0(1'b0, 1'b1, 1'b0, 32'hB00);
      check("to_early_grant", p0_sc_grant, 1'b1);
      tick();
      check("to_early_success", p0_success, 1'b1);

      reset = 1'b1;
      tick();
      check_all_zero("to_reset");
      reset = 1'b0;
      tick();

      // LL in cycle T; reservation expires after T+8, SC in T+9 fails
      drive0(1'b1, 1'b0, 1'b0, 32'hB00);
      tick();
      idle(7);
      check("to_expiry_cycle_linked", p0_linked, 1'b1);
      tick();
      check("to_expired", p0_linked, 1'b0);
      drive0(1'b0, 1'b1, 1'b0, 32'hB00);
      check("to_late_grant", p0_sc_grant, 1'b0);
      tick();
      check("to_late_success", p0_success, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
